// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the convolution address sequencer.
// State encoding, width helper and read-latency default.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int RD_LAT_DEF = 2;

  function automatic int clog2m(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_addr_sequencer_if.sv
// Control/datapath handshake bundle of the conv address sequencer.
// The sequencer is the slave; the layer controller/bench is the master.
interface conv_seq_if #(
  parameter int PIX_W = 1,
  parameter int MAP_W = 1
);
  logic               start;
  logic               stall;
  logic               busy;
  logic               done;
  logic               ag_reset;
  logic               ag_enable;
  logic               acc_valid;
  logic               acc_first;
  logic               acc_last;
  logic [2*PIX_W-1:0] pix_idx;
  logic [MAP_W-1:0]   map_idx;

  modport slave (
    input  start, stall,
    output busy, done, ag_reset, ag_enable,
    output acc_valid, acc_first, acc_last,
    output pix_idx, map_idx
  );

  modport master (
    output start, stall,
    input  busy, done, ag_reset, ag_enable,
    input  acc_valid, acc_first, acc_last,
    input  pix_idx, map_idx
  );
endinterface

// File: rtl/conv_addr_sequencer_delay.sv
// Fixed-depth tag shift register with synchronous clear.
// Aligns issue-time framing tags with BRAM read data.
module seq_delay_line #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_sr [D];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < D; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[D-1];
endmodule

// File: rtl/conv_addr_sequencer.sv
// Layer-level controller for the conv input-feature address generator.
// Gates addrgen enable, counts pairs and frames accumulator data.
module conv_addr_sequencer
  import conv_seq_pkg::*;
#(
  parameter int WIN_CYCLES  = 13,
  parameter int CH_ITERS    = 4,
  parameter int OUT_W       = 24,
  parameter int NUM_ONEMULT = 2,
  parameter int RD_LAT      = RD_LAT_DEF
) (
  input logic      clk,
  input logic      reset,
  conv_seq_if.slave bus
);
  localparam int WIN_W = clog2m(WIN_CYCLES);
  localparam int CH_W  = clog2m(CH_ITERS);
  localparam int PIX_W = clog2m(OUT_W);
  localparam int MAP_W = clog2m(NUM_ONEMULT);
  localparam int DRN_W = clog2m(RD_LAT);
  localparam int TAG_W = 3 + 2*PIX_W + MAP_W;

  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(WIN_CYCLES-1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CH_ITERS-1);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(OUT_W-1);
  localparam logic [MAP_W-1:0] MAP_MAX = MAP_W'(NUM_ONEMULT-1);
  localparam logic [DRN_W-1:0] DRN_MAX = DRN_W'(RD_LAT-1);

  state_t           r_state, w_next;
  logic [WIN_W-1:0] r_win;
  logic [CH_W-1:0]  r_ch;
  logic [PIX_W-1:0] r_row, r_col;
  logic [MAP_W-1:0] r_map;
  logic [DRN_W-1:0] r_drn;

  logic w_en, w_win_end, w_ch_end, w_col_end;
  logic w_row_end, w_all_end, w_v;
  logic [TAG_W-1:0] w_tag, w_q;

  assign w_en      = !reset && r_state == S_RUN && !bus.stall;
  assign w_win_end = r_win == WIN_MAX;
  assign w_ch_end  = w_win_end && r_ch == CH_MAX;
  assign w_col_end = w_ch_end && r_col == PIX_MAX;
  assign w_row_end = w_col_end && r_row == PIX_MAX;
  assign w_all_end = w_row_end && r_map == MAP_MAX;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   if (w_en && w_all_end) w_next = S_DRAIN;
      S_DRAIN: if (r_drn == DRN_MAX) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != S_DRAIN) r_drn <= '0;
    else                             r_drn <= r_drn + 1'b1;
  end

  // nested issue counters, innermost (window) first
  always_ff @(posedge clk) begin
    if (reset || r_state == S_CLEAR) begin
      r_win <= '0;
      r_ch  <= '0;
      r_col <= '0;
      r_row <= '0;
      r_map <= '0;
    end else if (w_en) begin
      r_win <= w_win_end ? '0 : r_win + 1'b1;
      if (w_win_end) r_ch  <= w_ch_end  ? '0 : r_ch + 1'b1;
      if (w_ch_end)  r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
      if (w_row_end) r_map <= w_all_end ? '0 : r_map + 1'b1;
    end
  end

  assign w_tag = {w_en, (r_win == '0 && r_ch == '0), w_ch_end,
                  r_row, r_col, r_map};

  seq_delay_line #(.W(TAG_W), .D(RD_LAT)) u_dl (
    .clk  (clk),
    .i_clr(reset),
    .i_d  (w_tag),
    .o_q  (w_q)
  );

  assign w_v = !reset && w_q[TAG_W-1];

  assign bus.busy      = !reset && r_state != S_IDLE;
  assign bus.done      = !reset && r_state == S_DONE;
  assign bus.ag_reset  = reset || r_state == S_CLEAR;
  assign bus.ag_enable = w_en;
  assign bus.acc_valid = w_v;
  assign bus.acc_first = w_v && w_q[TAG_W-2];
  assign bus.acc_last  = w_v && w_q[TAG_W-3];
  assign bus.pix_idx   = w_v ? w_q[MAP_W +: 2*PIX_W] : '0;
  assign bus.map_idx   = w_v ? w_q[MAP_W-1:0] : '0;
endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Scoreboard bench for conv_addr_sequencer (small layer geometry).
// Second instance exercises two output maps per multiplier.
module tb_conv_addr_sequencer;
  import conv_seq_pkg::*;

  localparam int WC    = 3;
  localparam int CI    = 2;
  localparam int OW    = 2;
  localparam int NM    = 1;
  localparam int RL    = 2;
  localparam int PW    = clog2m(OW);
  localparam int MW    = clog2m(NM);
  localparam int MW2   = clog2m(2);
  localparam int TOT   = WC*CI*OW*OW*NM;
  localparam int NLAST = OW*OW*NM;
  localparam int TOT2  = WC*CI*OW*OW*2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_seq_if #(.PIX_W(PW), .MAP_W(MW))  bus ();
  conv_seq_if #(.PIX_W(PW), .MAP_W(MW2)) bus2 ();

  conv_addr_sequencer #(
    .WIN_CYCLES(WC), .CH_ITERS(CI), .OUT_W(OW),
    .NUM_ONEMULT(NM), .RD_LAT(RL)
  ) u_dut (.clk(clk), .reset(rst), .bus(bus));

  conv_addr_sequencer #(
    .WIN_CYCLES(WC), .CH_ITERS(CI), .OUT_W(OW),
    .NUM_ONEMULT(2), .RD_LAT(RL)
  ) u_dut2 (.clk(clk), .reset(rst), .bus(bus2));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  typedef struct {
    int   due;
    logic f;
    logic l;
    int   row;
    int   col;
    int   map;
  } tag_t;

  tag_t sb[$];
  int ms = 0;
  int mk = 0;
  int mdrn = 0;
  int n_vld = 0;
  int n_last = 0;
  int last_vcyc = -10;
  logic last_vl = 1'b0;

  always @(negedge clk) begin
    logic e_en;
    tag_t t;
    int px;
    cyc++;
    if (rst) begin
      chk("ctl_rst", {bus.busy, bus.done, bus.ag_reset, bus.ag_enable},
          4'b0010);
      chk("vld_rst", bus.acc_valid, 0);
      chk("tag_rst", {bus.acc_first, bus.acc_last, bus.pix_idx,
                      bus.map_idx}, 0);
      sb.delete();
      ms = 0; mk = 0; n_vld = 0; n_last = 0;
    end else begin
      e_en = (ms == 2) && !bus.stall;
      chk("ctl", {bus.busy, bus.done, bus.ag_reset, bus.ag_enable},
          {ms != 0, ms == 4, ms == 1, e_en});
      if (sb.size() > 0 && sb[0].due == cyc) begin
        t = sb.pop_front();
        chk("vld", bus.acc_valid, 1);
        chk("first", bus.acc_first, t.f);
        chk("last", bus.acc_last, t.l);
        chk("pix", bus.pix_idx, (t.row << PW) | t.col);
        chk("map", bus.map_idx, t.map);
        n_vld++;
        if (t.l) n_last++;
        last_vcyc = cyc;
        last_vl = t.l;
      end else begin
        chk("idle_vld", bus.acc_valid, 0);
        chk("idle_tag", {bus.acc_first, bus.acc_last, bus.pix_idx,
                         bus.map_idx}, 0);
      end
      if (ms == 4) begin
        chk("n_vld", n_vld, TOT);
        chk("n_last", n_last, NLAST);
        chk("done_after_last", cyc - last_vcyc, 1);
        chk("final_is_last", last_vl, 1);
        n_vld = 0; n_last = 0;
      end
      case (ms)
        0: if (bus.start) ms = 1;
        1: begin ms = 2; mk = 0; end
        2: if (e_en) begin
          px    = mk / (WC*CI);
          t.due = cyc + RL;
          t.f   = (mk % WC == 0) && ((mk / WC) % CI == 0);
          t.l   = (mk % WC == WC-1) && ((mk / WC) % CI == CI-1);
          t.col = px % OW;
          t.row = (px / OW) % OW;
          t.map = px / (OW*OW);
          sb.push_back(t);
          mk++;
          if (mk == TOT) begin ms = 3; mdrn = 0; end
        end
        3: begin mdrn++; if (mdrn == RL) ms = 4; end
        default: ms = 0;
      endcase
    end
  end

  int q2[$];
  int n_last2 = 0;
  int n_vld2 = 0;

  always @(negedge clk) begin
    if (!rst && bus2.acc_valid) n_vld2++;
    if (!rst && bus2.acc_last) begin
      n_last2++;
      if (q2.size() == 0) chk("m2_extra_last", 1, 0);
      else chk("m2_seq", {bus2.map_idx, bus2.pix_idx}, q2.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((ms != 0 || bus.busy) && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < lim, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus2.start = 1'b0;
    bus2.stall = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    pulse_start();
    wait_idle(200);
    tick();

    pulse_start();
    repeat (4) tick();
    bus.stall = 1'b1;
    repeat (3) tick();
    bus.stall = 1'b0;
    wait_idle(200);
    tick();

    pulse_start();
    repeat (24) tick();
    chk("pre_final_issue", mk, TOT-1);
    bus.stall = 1'b1;
    repeat (4) tick();
    bus.stall = 1'b0;
    wait_idle(200);
    tick();

    pulse_start();
    repeat (5) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (ms != 4 && n < 200) begin tick(); n++; end
    chk("done_timeout", n < 200, 1);
    bus.start = 1'b1;
    repeat (2) tick();
    bus.start = 1'b0;
    chk("restart_run", bus.busy, 1);
    wait_idle(200);
    tick();

    pulse_start();
    n = 0;
    while (mk != 10 && n < 200) begin tick(); n++; end
    chk("mid_timeout", n < 200, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    pulse_start();
    wait_idle(200);
    tick();

    for (int m = 0; m < 2; m++)
      for (int r = 0; r < OW; r++)
        for (int c = 0; c < OW; c++)
          q2.push_back((m << (2*PW)) | (r << PW) | c);
    n_last2 = 0;
    n_vld2 = 0;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    n = 0;
    while (!bus2.done && n < 300) begin tick(); n++; end
    chk("m2_timeout", n < 300, 1);
    tick();
    chk("m2_nlast", n_last2, 2*OW*OW);
    chk("m2_nvld", n_vld2, TOT2);
    chk("m2_q_empty", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
